uart_tx: RTL and testbench

- UART transmitter, the companion to the board's UART receive path.
- Accepts bytes over a valid/ready handshake into a small internal FIFO and serialises them on tx_o.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Bit timing is derived from sysclk by an internal prescaler; the block sits between user logic and the board's UART TX pin.

---
 rtl/uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_tx : FIFO-buffered UART transmitter, LSB first, opt. parity |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             sysclk,
  input  logic                             reset_n,
  input  logic [7:0]                       tx_data,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  output logic                             tx_o,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int PRE_W = $clog2(CLKS_PER_BIT);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PRE_W-1:0]     prescale_q, prescale_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;
  logic                 bit_end;
  logic [DATA_BITS-1:0] head;
  logic                 unused_data;

  // Upper tx_data bits are ignored when DATA_BITS < 8.
  assign unused_data = ^tx_data;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    push       = tx_valid && !fifo_full;
    head       = mem_q[rd_ptr_q];
    bit_end    = (prescale_q == PRE_LAST);
    pop        = 1'b0;
    state_d    = state_q;
    prescale_d = bit_end ? '0 : prescale_q + PRE_W'(1);
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        prescale_d = '0;
        pop        = !fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == DATA_LAST) begin
            if (PARITY != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d      = 1'b1;
              bit_idx_d = '0;
              state_d   = S_STOP;
            end
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tx_d      = 1'b1;
          bit_idx_d = '0;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        // bit_idx counts stop bits here; a waiting word starts with no idle gap.
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            pop = !fifo_empty;
            if (fifo_empty) begin
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      shift_d    = head;
      parity_d   = (PARITY == 1) ? ~^head : ^head;
      tx_d       = 1'b0;
      prescale_d = '0;
      state_d    = S_START;
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      prescale_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      prescale_q <= prescale_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data[DATA_BITS-1:0];
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready   = !fifo_full;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_tx : several uart_tx configurations against a line model |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_tx;

  localparam int NCFG = 4;

  logic             sysclk;
  logic             reset_n;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic [NCFG-1:0]  tx_w;
  logic [NCFG-1:0]  ready_w;
  logic [NCFG-1:0]  busy_w;
  bit               chk_en;
  int               n_tests;
  int               n_fail;

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic int cfg_cpb(int g);
    return (g == 3) ? 2 : 4;
  endfunction
  function automatic int cfg_db(int g);
    return (g == 3) ? 5 : 8;
  endfunction
  function automatic int cfg_par(int g);
    return (g == 1) ? 2 : ((g == 0) ? 0 : 1);
  endfunction
  function automatic int cfg_stop(int g);
    return (g == 1 || g == 3) ? 2 : 1;
  endfunction
  function automatic int cfg_depth(int g);
    return (g == 3) ? 2 : 4;
  endfunction
  function automatic int frame_len(int g);
    return (1 + cfg_db(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_stop(g)) * cfg_cpb(g);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int CPB   = cfg_cpb(g);
    localparam int DB    = cfg_db(g);
    localparam int PAR   = cfg_par(g);
    localparam int STOPB = cfg_stop(g);
    localparam int DEPTH = cfg_depth(g);

    logic [$clog2(DEPTH+1)-1:0] cnt;
    byte unsigned mq[$];
    bit           lq[$];
    bit           in_frame = 1'b0;
    bit           exp_tx   = 1'b1;

    uart_tx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (DB),
      .PARITY       (PAR),
      .STOP_BITS    (STOPB),
      .FIFO_DEPTH   (DEPTH)
    ) u_dut (
      .sysclk     (sysclk),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (ready_w[g]),
      .tx_o       (tx_w[g]),
      .busy       (busy_w[g]),
      .fifo_count (cnt)
    );

    // Reference: a queue of words and a queue of per-cycle line levels.
    always @(posedge sysclk) begin
      byte unsigned d;
      bit acc;
      if (!reset_n) begin
        mq.delete();
        lq.delete();
        in_frame = 1'b0;
        exp_tx   = 1'b1;
      end else begin
        acc = tx_valid && (mq.size() < DEPTH);
        if (lq.size() == 0 && mq.size() != 0) begin
          d = mq.pop_front();
          repeat (CPB) lq.push_back(1'b0);
          for (int i = 0; i < DB; i++) begin
            repeat (CPB) lq.push_back(d[i]);
          end
          if (PAR != 0) begin
            repeat (CPB) lq.push_back((PAR == 2) ? ^d : ~^d);
          end
          repeat (STOPB * CPB) lq.push_back(1'b1);
        end
        in_frame = (lq.size() != 0);
        exp_tx   = in_frame ? lq.pop_front() : 1'b1;
        if (acc) mq.push_back(tx_data & 8'((1 << DB) - 1));
      end
    end

    always @(negedge sysclk) begin
      if (chk_en) begin
        check($sformatf("c%0d_tx", g), tx_w[g], exp_tx);
        check($sformatf("c%0d_count", g), cnt, mq.size());
        check($sformatf("c%0d_ready", g), ready_w[g], (mq.size() < DEPTH) ? 1 : 0);
        check($sformatf("c%0d_busy", g), busy_w[g], (in_frame || mq.size() != 0) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(negedge sysclk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy_w != '0 && n < limit) begin
      tick();
      n++;
    end
    if (busy_w != '0) check("idle_timeout", busy_w, 0);
  endtask

  // Push nw words back-to-back into an idle block and time the busy window.
  task automatic send_timed(input logic [7:0] d0, input logic [7:0] d1, input int nw);
    int fall [NCFG];
    for (int g = 0; g < NCFG; g++) fall[g] = 0;
    for (int w = 0; w < nw; w++) begin
      tx_valid = 1'b1;
      tx_data  = (w == 0) ? d0 : d1;
      tick();
    end
    tx_valid = 1'b0;
    for (int n = 1; n <= 250; n++) begin
      tx_data = 8'($urandom);
      tick();
      for (int g = 0; g < NCFG; g++) begin
        if (fall[g] == 0 && !busy_w[g]) fall[g] = n;
      end
    end
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("busy_len_c%0d", g), fall[g], nw * frame_len(g) + 2 - nw);
    end
  endtask

  initial begin
    int acc [NCFG];
    int pushed;
    n_tests  = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_tx", tx_w, {NCFG{1'b1}});
    check("rst_ready", ready_w, {NCFG{1'b1}});
    check("rst_busy", busy_w, 0);
    check("rst_count0", g_cfg[0].cnt, 0);
    reset_n = 1'b1;
    tick();

    send_timed(8'h55, 8'h00, 1);
    send_timed(8'h07, 8'h00, 1);
    send_timed(8'hA3, 8'h3C, 2);

    for (int g = 0; g < NCFG; g++) acc[g] = 0;
    for (int i = 1; i <= 8; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(i);
      for (int g = 0; g < NCFG; g++) begin
        if (ready_w[g]) acc[g]++;
      end
      if (i == 6) check("ready_6th", ready_w[0], 0);
      tick();
    end
    tx_valid = 1'b0;
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("burst_acc_c%0d", g), acc[g], cfg_depth(g) + 1);
    end
    wait_idle(2000);

    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    repeat (15) tick();
    check("pre_rst_count0", g_cfg[0].cnt, 2);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_tx", tx_w, {NCFG{1'b1}});
    check("mid_rst_busy", busy_w, 0);
    check("mid_rst_count0", g_cfg[0].cnt, 0);
    send_timed(8'($urandom), 8'h00, 1);

    pushed = 0;
    for (int c = 0; c < 4000 && pushed < 16; c++) begin
      tx_valid = ($urandom_range(0, 1) == 1) && (g_cfg[0].cnt <= 2);
      tx_data  = 8'($urandom);
      if (tx_valid && ready_w[0]) pushed++;
      tick();
    end
    tx_valid = 1'b0;
    check("rand_pushed", pushed, 16);
    wait_idle(4000);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
